// File: rtl/proc_scheduler.sv
// Round-robin process scheduler: per-slot process table, time-slice counter and dispatch FSM.
// Optional macro PROC_SCHED_STATS_EN adds a saturating 16-bit preempt_count output.
module proc_scheduler #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_PROCS   = 4,
  parameter int SLICE_W     = 16,
  parameter int SLICE_RESET = 100,
  localparam int ID_W       = $clog2(NUM_PROCS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  count_en,
  input  logic                  slice_load,
  input  logic [SLICE_W-1:0]    slice_value,
  input  logic                  create_valid,
  input  logic [DATA_WIDTH-1:0] create_base,
  input  logic [DATA_WIDTH-1:0] create_pc,
  output logic                  create_ready,
  output logic [ID_W-1:0]       create_id,
  input  logic                  finish,
  input  logic                  ctx_save,
  input  logic [DATA_WIDTH-1:0] ctx_pc,
  input  logic                  dispatch,
  output logic                  preempt,
  output logic                  next_valid,
  output logic [ID_W-1:0]       next_id,
  output logic [DATA_WIDTH-1:0] next_base,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic [ID_W-1:0]       cur_id,
  output logic                  running,
  output logic [NUM_PROCS-1:0]  active_mask
`ifdef PROC_SCHED_STATS_EN
  ,
  output logic [15:0]           preempt_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED, S_SWITCH} state_e;

  state_e                  state_q, state_d;
  logic [NUM_PROCS-1:0]    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   base_q [NUM_PROCS];
  logic [DATA_WIDTH-1:0]   base_d [NUM_PROCS];
  logic [DATA_WIDTH-1:0]   pc_q   [NUM_PROCS];
  logic [DATA_WIDTH-1:0]   pc_d   [NUM_PROCS];
  logic [ID_W-1:0]         cur_id_q, cur_id_d;
  logic [SLICE_W-1:0]      counter_q, counter_d;
  logic [SLICE_W-1:0]      quantum_q, quantum_d;
  logic                    preempt_q, preempt_d;
  logic                    running_q, running_d;

  logic                    free_found, sel_found, finish_hit;
  logic [ID_W-1:0]         free_idx, sel_idx, cand;

  // Lowest free slot for creation; round-robin successor of cur_id for dispatch.
  always_comb begin
    // NOTE: every combinational variable gets a default first, so no latch is inferred.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_PROCS; i++) begin
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = ID_W'(i);
      end
    end
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_PROCS; i++) begin
      cand = cur_id_q + ID_W'(i);
      if (!sel_found && valid_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    base_d     = base_q;
    pc_d       = pc_q;
    cur_id_d   = cur_id_q;
    counter_d  = counter_q;
    quantum_d  = slice_load ? slice_value : quantum_q;
    preempt_d  = 1'b0;
    finish_hit = finish && (state_q == S_RUN || state_q == S_EXPIRED);

    // Finish clears first so a create into the same slot wins.
    if (finish_hit) valid_d[cur_id_q] = 1'b0;
    if (create_valid && free_found) begin
      valid_d[free_idx] = 1'b1;
      base_d[free_idx]  = create_base;
      pc_d[free_idx]    = create_pc;
    end

    case (state_q)
      S_IDLE, S_SWITCH: begin
        if (dispatch && sel_found) begin
          state_d   = S_RUN;
          cur_id_d  = sel_idx;
          counter_d = quantum_q;
        end
      end
      S_RUN: begin
        if (finish_hit) begin
          state_d = (|valid_d) ? S_SWITCH : S_IDLE;
        end else if (count_en && counter_q != '0) begin
          counter_d = counter_q - SLICE_W'(1);
          if (counter_q == SLICE_W'(1)) begin
            state_d   = S_EXPIRED;
            preempt_d = 1'b1;
          end
        end
      end
      S_EXPIRED: begin
        if (finish_hit) begin
          state_d = (|valid_d) ? S_SWITCH : S_IDLE;
        end else if (ctx_save) begin
          pc_d[cur_id_q] = ctx_pc;
          state_d        = S_SWITCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    running_d = (state_d == S_RUN) || (state_d == S_EXPIRED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      cur_id_q  <= '0;
      counter_q <= '0;
      quantum_q <= SLICE_W'(SLICE_RESET);
      preempt_q <= 1'b0;
      running_q <= 1'b0;
      // NOTE: the table is a flop array rather than a RAM, so it can and must be cleared on reset.
      for (int i = 0; i < NUM_PROCS; i++) begin
        base_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      // NOTE: <= keeps every flop sampling pre-edge values regardless of statement order.
      state_q   <= state_d;
      valid_q   <= valid_d;
      cur_id_q  <= cur_id_d;
      counter_q <= counter_d;
      quantum_q <= quantum_d;
      preempt_q <= preempt_d;
      running_q <= running_d;
      base_q    <= base_d;
      pc_q      <= pc_d;
    end
  end

`ifdef PROC_SCHED_STATS_EN
  logic [15:0] preempt_count_q, preempt_count_d;

  always_comb begin
    preempt_count_d = preempt_count_q;
    if (preempt_d && preempt_count_q != 16'hFFFF) preempt_count_d = preempt_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) preempt_count_q <= '0;
    else        preempt_count_q <= preempt_count_d;
  end

  assign preempt_count = preempt_count_q;
`endif

  assign create_ready = free_found;
  assign create_id    = free_idx;
  assign next_valid   = sel_found;
  assign next_id      = sel_idx;
  assign next_base    = base_q[sel_idx];
  assign next_pc      = pc_q[sel_idx];
  assign cur_id       = cur_id_q;
  assign running      = running_q;
  assign preempt      = preempt_q;
  assign active_mask  = valid_q;

endmodule

// File: tb/tb_proc_scheduler.sv
// Self-checking bench for proc_scheduler: directed vector table, corner sequences, random vs. model.
`timescale 1ns/1ps
module tb_proc_scheduler;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int SW = 16;
  localparam int IW = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           count_en = 1'b0, slice_load = 1'b0;
  logic [SW-1:0]  slice_value = '0;
  logic           create_valid = 1'b0;
  logic [DW-1:0]  create_base = '0, create_pc = '0;
  logic           create_ready;
  logic [IW-1:0]  create_id;
  logic           finish = 1'b0, ctx_save = 1'b0, dispatch = 1'b0;
  logic [DW-1:0]  ctx_pc = '0;
  logic           preempt, next_valid, running;
  logic [IW-1:0]  next_id, cur_id;
  logic [DW-1:0]  next_base, next_pc;
  logic [NP-1:0]  active_mask;
`ifdef PROC_SCHED_STATS_EN
  logic [15:0]    preempt_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  proc_scheduler #(.DATA_WIDTH(DW), .NUM_PROCS(NP), .SLICE_W(SW), .SLICE_RESET(100)) dut (
    .clock(clock), .reset(reset),
    .count_en(count_en), .slice_load(slice_load), .slice_value(slice_value),
    .create_valid(create_valid), .create_base(create_base), .create_pc(create_pc),
    .create_ready(create_ready), .create_id(create_id),
    .finish(finish), .ctx_save(ctx_save), .ctx_pc(ctx_pc), .dispatch(dispatch),
    .preempt(preempt), .next_valid(next_valid), .next_id(next_id),
    .next_base(next_base), .next_pc(next_pc),
    .cur_id(cur_id), .running(running), .active_mask(active_mask)
`ifdef PROC_SCHED_STATS_EN
    , .preempt_count(preempt_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ctl = {create_valid, dispatch, count_en, finish, ctx_save, slice_load}
  task automatic do_cycle(input logic [5:0] ctl, input logic [31:0] a, input logic [31:0] b);
    {create_valid, dispatch, count_en, finish, ctx_save, slice_load} = ctl;
    create_base = a;
    create_pc   = b;
    ctx_pc      = a;
    slice_value = a[15:0];
    @(posedge clock);
    #1;
    {create_valid, dispatch, count_en, finish, ctx_save, slice_load} = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".preempt"}, 64'(preempt), 64'(0));
    check({tag, ".running"}, 64'(running), 64'(0));
    check({tag, ".mask"}, 64'(active_mask), 64'(0));
    check({tag, ".cur_id"}, 64'(cur_id), 64'(0));
    check({tag, ".next_valid"}, 64'(next_valid), 64'(0));
    check({tag, ".create_ready"}, 64'(create_ready), 64'(1));
    check({tag, ".create_id"}, 64'(create_id), 64'(0));
`ifdef PROC_SCHED_STATS_EN
    check({tag, ".preempt_count"}, 64'(preempt_count), 64'(0));
`endif
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  eflg;   // {preempt, running, next_valid, create_ready}
    logic [1:0]  ecur;
    logic [1:0]  enid;
    logic [1:0]  ecid;
    logic [3:0]  emask;
    logic [31:0] enpc;
  } vec_t;

  vec_t vecs [24];

  // ---------------- behavioural reference model ----------------
  bit [NP-1:0]  m_valid;
  logic [DW-1:0] m_base [NP];
  logic [DW-1:0] m_pc   [NP];
  int  m_cur, m_left, m_quantum, m_pcount;
  bit  m_active, m_expired, m_preempt;

  function automatic int m_free_slot();
    for (int i = 0; i < NP; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic int m_next();
    for (int k = 1; k <= NP; k++) if (m_valid[(m_cur + k) % NP]) return (m_cur + k) % NP;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = '0;
    for (int i = 0; i < NP; i++) begin m_base[i] = '0; m_pc[i] = '0; end
    m_cur = 0; m_left = 0; m_quantum = 100; m_pcount = 0;
    m_active = 0; m_expired = 0; m_preempt = 0;
  endtask

  task automatic model_step();
    int fs, nx;
    bit fin, pre;
    fs  = m_free_slot();
    nx  = m_next();
    fin = finish && m_active;
    pre = 0;
    if (fin) m_valid[m_cur] = 0;
    if (create_valid && fs >= 0) begin
      m_valid[fs] = 1; m_base[fs] = create_base; m_pc[fs] = create_pc;
    end
    if (!m_active) begin
      if (dispatch && nx >= 0) begin
        m_active = 1; m_expired = 0; m_cur = nx; m_left = m_quantum;
      end
    end else if (fin) begin
      m_active = 0;
    end else if (m_expired) begin
      if (ctx_save) begin m_pc[m_cur] = ctx_pc; m_active = 0; end
    end else if (count_en && m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_expired = 1; pre = 1; end
    end
    m_preempt = pre;
    if (pre && m_pcount < 65535) m_pcount++;
    if (slice_load) m_quantum = int'(slice_value);
  endtask

  task automatic compare_all(input string tag);
    int nx, fs;
    nx = m_next();
    fs = m_free_slot();
    check({tag, ".preempt"}, 64'(preempt), 64'(m_preempt));
    check({tag, ".running"}, 64'(running), 64'(m_active));
    check({tag, ".cur_id"}, 64'(cur_id), 64'(m_cur));
    check({tag, ".mask"}, 64'(active_mask), 64'(m_valid));
    check({tag, ".next_valid"}, 64'(next_valid), 64'(nx >= 0));
    if (nx >= 0) begin
      check({tag, ".next_id"}, 64'(next_id), 64'(nx));
      check({tag, ".next_base"}, 64'(next_base), 64'(m_base[nx]));
      check({tag, ".next_pc"}, 64'(next_pc), 64'(m_pc[nx]));
    end
    check({tag, ".create_ready"}, 64'(create_ready), 64'(fs >= 0));
    if (fs >= 0) check({tag, ".create_id"}, 64'(create_id), 64'(fs));
`ifdef PROC_SCHED_STATS_EN
    check({tag, ".preempt_count"}, 64'(preempt_count), 64'(m_pcount));
`endif
  endtask

  initial begin
    logic acc;

    vecs[0]  = '{6'b000001, 32'd3,    32'h0,  4'b0001, 2'd0, 2'd0, 2'd0, 4'b0000, 32'h0};
    vecs[1]  = '{6'b100000, 32'h400,  32'h10, 4'b0011, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h10};
    vecs[2]  = '{6'b011000, 32'h0,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h10};
    vecs[3]  = '{6'b001000, 32'h0,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h10};
    vecs[4]  = '{6'b001000, 32'h0,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h10};
    vecs[5]  = '{6'b001000, 32'h0,    32'h0,  4'b1111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h10};
    vecs[6]  = '{6'b001000, 32'h0,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h10};
    vecs[7]  = '{6'b100000, 32'h500,  32'h20, 4'b0111, 2'd0, 2'd1, 2'd2, 4'b0011, 32'h20};
    vecs[8]  = '{6'b000010, 32'h44,   32'h0,  4'b0011, 2'd0, 2'd1, 2'd2, 4'b0011, 32'h20};
    vecs[9]  = '{6'b010000, 32'h0,    32'h0,  4'b0111, 2'd1, 2'd0, 2'd2, 4'b0011, 32'h44};
    vecs[10] = '{6'b000100, 32'h0,    32'h0,  4'b0011, 2'd1, 2'd0, 2'd1, 4'b0001, 32'h44};
    vecs[11] = '{6'b010010, 32'h99,   32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h44};
    vecs[12] = '{6'b001001, 32'd5,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h44};
    vecs[13] = '{6'b000000, 32'h0,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h44};
    vecs[14] = '{6'b001000, 32'h0,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h44};
    vecs[15] = '{6'b000000, 32'h0,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h44};
    vecs[16] = '{6'b001000, 32'h0,    32'h0,  4'b1111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h44};
    vecs[17] = '{6'b000010, 32'h50,   32'h0,  4'b0011, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h50};
    vecs[18] = '{6'b010000, 32'h0,    32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h50};
    for (int i = 19; i <= 22; i++)
      vecs[i] = '{6'b001000, 32'h0,   32'h0,  4'b0111, 2'd0, 2'd0, 2'd1, 4'b0001, 32'h50};
    vecs[23] = '{6'b001100, 32'h0,    32'h0,  4'b0001, 2'd0, 2'd0, 2'd0, 4'b0000, 32'h0};

    // Reset state, asserted from time zero.
    #2;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 24; i++) begin
      do_cycle(vecs[i].ctl, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d.flags", i), 64'({preempt, running, next_valid, create_ready}), 64'(vecs[i].eflg));
      check($sformatf("vec%0d.cur_id", i), 64'(cur_id), 64'(vecs[i].ecur));
      check($sformatf("vec%0d.mask", i), 64'(active_mask), 64'(vecs[i].emask));
      if (vecs[i].eflg[1]) begin
        check($sformatf("vec%0d.next_id", i), 64'(next_id), 64'(vecs[i].enid));
        check($sformatf("vec%0d.next_pc", i), 64'(next_pc), 64'(vecs[i].enpc));
      end
      if (vecs[i].eflg[0]) check($sformatf("vec%0d.create_id", i), 64'(create_id), 64'(vecs[i].ecid));
    end

    // Three processes, round-robin around an expiry and a context save.
    do_cycle(6'b000001, 32'd1, 32'h0);
    do_cycle(6'b100000, 32'h100, 32'h10);
    do_cycle(6'b100000, 32'h101, 32'h20);
    do_cycle(6'b100000, 32'h102, 32'h30);
    do_cycle(6'b010000, 32'h0, 32'h0);
    check("rr.cur_id_1", 64'(cur_id), 64'(1));
    do_cycle(6'b001000, 32'h0, 32'h0);
    check("rr.preempt_1", 64'(preempt), 64'(1));
    do_cycle(6'b000010, 32'h88, 32'h0);
    check("rr.next_after_1", 64'(next_id), 64'(2));
    check("rr.running_switch", 64'(running), 64'(0));
    do_cycle(6'b010000, 32'h0, 32'h0);
    do_cycle(6'b001000, 32'h0, 32'h0);
    check("rr.preempt_2", 64'(preempt), 64'(1));
    check("rr.next_after_2", 64'(next_id), 64'(0));
    do_cycle(6'b000010, 32'hA2, 32'h0);
    do_cycle(6'b010000, 32'h0, 32'h0);
    check("rr.next_after_0", 64'(next_id), 64'(1));
    check("rr.saved_pc_1", 64'(next_pc), 64'h88);

    // Full table, ignored create, then a finish frees the running slot.
    do_cycle(6'b100000, 32'h103, 32'h40);
    check("full.create_ready", 64'(create_ready), 64'(0));
    check("full.mask", 64'(active_mask), 64'hF);
    do_cycle(6'b100000, 32'hDEAD, 32'hBEEF);
    check("full.mask_after_ignored", 64'(active_mask), 64'hF);
    check("full.next_base", 64'(next_base), 64'h101);
    do_cycle(6'b001000, 32'h0, 32'h0);
    do_cycle(6'b000010, 32'h11, 32'h0);
    do_cycle(6'b010000, 32'h0, 32'h0);
    do_cycle(6'b001000, 32'h0, 32'h0);
    do_cycle(6'b000010, 32'h22, 32'h0);
    do_cycle(6'b010000, 32'h0, 32'h0);
    check("full.cur_id_2", 64'(cur_id), 64'(2));
    do_cycle(6'b000100, 32'h0, 32'h0);
    check("fin.create_ready", 64'(create_ready), 64'(1));
    check("fin.create_id", 64'(create_id), 64'(2));
    check("fin.mask", 64'(active_mask), 64'hB);
    check("fin.running", 64'(running), 64'(0));
    check("fin.next_id", 64'(next_id), 64'(3));

    // Reset mid-slice, then no preempt until a new dispatch; quantum back to 100.
    do_cycle(6'b000001, 32'd4, 32'h0);
    do_cycle(6'b010000, 32'h0, 32'h0);
    do_cycle(6'b001000, 32'h0, 32'h0);
    count_en = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clock);
    reset = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_cycle(6'b001000, 32'h0, 32'h0);
      acc = acc | preempt | running;
    end
    check("post_reset.quiet", 64'(acc), 64'(0));
    do_cycle(6'b100000, 32'h1, 32'h2);
    do_cycle(6'b011000, 32'h0, 32'h0);
    acc = 1'b0;
    for (int i = 0; i < 99; i++) begin
      do_cycle(6'b001000, 32'h0, 32'h0);
      acc = acc | preempt;
    end
    check("quantum100.early", 64'(acc), 64'(0));
    do_cycle(6'b001000, 32'h0, 32'h0);
    check("quantum100.expire", 64'(preempt), 64'(1));
`ifdef PROC_SCHED_STATS_EN
    check("stats.one", 64'(preempt_count), 64'(1));
`endif

    // Randomized run against the reference model.
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("rand_reset");
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("rand_midreset");
        @(negedge clock);
        reset = 1'b1;
      end
      create_valid = ($urandom_range(0, 9) < 3);
      create_base  = $urandom();
      create_pc    = $urandom();
      dispatch     = ($urandom_range(0, 9) < 3);
      count_en     = ($urandom_range(0, 9) < 7);
      finish       = ($urandom_range(0, 99) < 8);
      ctx_save     = ($urandom_range(0, 9) < 3);
      ctx_pc       = $urandom();
      slice_load   = ($urandom_range(0, 99) < 5);
      slice_value  = 16'($urandom_range(0, 4));
      @(posedge clock);
      model_step();
      #1;
      compare_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_scheduler.md
PROC_SCHEDULER -- requirements
Module: proc_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of base-register and PC values.
REQ-002 SHALL have parameter NUM_PROCS, default 4, process-table slots (power of two, 2..16); ID_W = log2(NUM_PROCS).
REQ-003 SHALL have parameter SLICE_W, default 16, time-slice counter width.
REQ-004 SHALL have parameter SLICE_RESET, default 100, quantum after reset.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports clock and reset.
REQ-006 Ports: clock in 1, system clock; reset in 1, async active-low reset.
REQ-007 Ports: count_en in 1, user process executing, so the slice counter may decrement; slice_load in 1 and slice_value in SLICE_W, quantum write.
REQ-008 Ports: create_valid in 1, create_base in DATA_WIDTH, create_pc in DATA_WIDTH, new-process request; create_ready out 1, free slot exists; create_id out ID_W, slot to be allocated.
REQ-009 Ports: finish in 1, current process terminated; ctx_save in 1 and ctx_pc in DATA_WIDTH, OS saves current PC; dispatch in 1, OS starts selected process.
REQ-010 Ports: preempt out 1, slice-expiry pulse; next_valid out 1, next_id out ID_W, next_base out DATA_WIDTH, next_pc out DATA_WIDTH, selected process; cur_id out ID_W; running out 1; active_mask out NUM_PROCS.

Function
REQ-011 Table per slot: valid bit, base, pc; all writes happen on the rising clock edge.
REQ-012 create_id SHALL equal the lowest-index free slot; create_ready = any slot free; a create with create_ready=1 SHALL fill that slot and set its valid bit next cycle; a create with create_ready=0 SHALL be ignored.
REQ-013 FSM states are IDLE, RUN, EXPIRED, SWITCH. IDLE: running=0. dispatch while next_valid=1 moves to RUN, sets cur_id=next_id and reloads the counter with the quantum.
REQ-014 In RUN, when count_en=1 the counter SHALL decrement by 1 per cycle. When count_en=1 and the counter equals 1, the next edge SHALL assert preempt for exactly one cycle and enter EXPIRED. The counter SHALL not wrap below 0.
REQ-015 EXPIRED/SWITCH: count frozen, running=1 in EXPIRED only; ctx_save in EXPIRED SHALL write ctx_pc to table[cur_id].pc and move to SWITCH; dispatch in SWITCH behaves as REQ-013.
REQ-016 finish in RUN or EXPIRED SHALL clear valid[cur_id], go to SWITCH if another slot is valid, else IDLE; finish has priority over expiry and ctx_save in the same cycle.
REQ-017 Selection: next_id = first valid slot scanning cur_id+1, cur_id+2, ... modulo NUM_PROCS, including cur_id itself last; round-robin; combinational. next_valid=0 SHALL hold when no slot is valid.
REQ-018 dispatch outside IDLE/SWITCH, or with next_valid=0, SHALL be ignored; ctx_save outside EXPIRED SHALL be ignored.
REQ-019 slice_load SHALL update the quantum register and affect only the next reload, not the running count.
REQ-020 A create and a finish in the same cycle targeting the same slot SHALL leave the slot valid with the new contents.
REQ-021 active_mask SHALL mirror the valid bits.

Reset
REQ-022 On reset low, immediately: state IDLE, all valid=0, base/pc=0, cur_id=0, counter=0, quantum=SLICE_RESET, preempt=0, running=0.
REQ-023 Reset mid-slice SHALL discard the table; no preempt pulse SHALL occur on or after reset release until the next dispatch.

Configuration
REQ-024 Macro PROC_SCHED_STATS_EN: when defined, SHALL add output preempt_count (16 bits): counts preempt pulses, saturates at 0xFFFF, is cleared by reset. When undefined, the port and its logic SHALL be absent, with no other behaviour change.

Verification
REQ-025 Reset, create base 0x400 pc 0x10, dispatch, quantum 3, count_en=1 -> preempt is a one-cycle pulse exactly 3 cycles after dispatch; state EXPIRED.
REQ-026 Slots 0,1,2 valid, cur_id=1, expiry, ctx_save pc 0x88 -> table[1].pc=0x88, next_id=2; after dispatch of 2 and its expiry, next_id=0.
REQ-027 Fill 4 slots -> create_ready=0, further create ignored; finish on cur_id=2 -> create_ready=1, create_id=2.
REQ-028 count_en toggled 1,0,1,0 with quantum 2 -> preempt only after two enabled cycles; slice_load 5 mid-run does not alter current expiry.
REQ-029 Single process finish together with counter expiry -> no preempt, state IDLE, next_valid=0.
REQ-030 With PROC_SCHED_STATS_EN: 3 expiries -> preempt_count=3; reset asserted mid-slice -> preempt_count=0, all outputs at reset values.
